token_window_counter: RTL and testbench

//   Downstream consumer of the serial token stream produced by the token-halving stage.

---
 rtl/token_window_counter_if.sv | 22 ++
 rtl/token_window_counter.sv | 84 ++++++++
 tb/tb_token_window_counter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/token_window_counter_if.sv
// rtl/token_window_counter_if.sv - valid/ready bus carrying completed window totals
interface token_window_counter_if #(
    parameter int CNT_W = 5
);
    logic             count_valid;
    logic             count_ready;
    logic [CNT_W-1:0] count;

    // Producer side: the counter owns valid and the count word.
    modport master (
        output count_valid,
        output count,
        input  count_ready
    );

    // Consumer side: accepts words by raising ready.
    modport slave (
        input  count_valid,
        input  count,
        output count_ready
    );
endinterface

// File: rtl/token_window_counter.sv
// rtl/token_window_counter.sv - counts '1' tokens per fixed window, one-entry output slot, drop counter
module token_window_counter #(
    parameter int WINDOW = 16,
    parameter int CNT_W  = $clog2(WINDOW + 1),
    parameter int DROP_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    a,
    token_window_counter_if.master  cnt_if,
    output logic [DROP_W-1:0]       drops
);
    localparam logic [CNT_W-1:0]  LAST     = CNT_W'(WINDOW - 1);
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cyc;
    logic [CNT_W-1:0] acc;
    logic [CNT_W-1:0] total;
    logic             close;

    // The close-cycle token is part of its own window, so the total includes a.
    assign close = en && (cyc == LAST);
    assign total = acc + CNT_W'(a);

    // Window position and running token sum; both freeze while en is low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cyc <= '0;
            acc <= '0;
        end else if (en) begin
            if (cyc == LAST) begin
                cyc <= '0;
                acc <= '0;
            end else begin
                cyc <= cyc + CNT_W'(1);
                acc <= total;
            end
        end
    end

    // One-entry output slot: holds a total until accepted, counts totals lost while full.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state              <= EMPTY;
            cnt_if.count_valid <= 1'b0;
            cnt_if.count       <= '0;
            drops              <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (close) begin
                        state              <= FULL;
                        cnt_if.count_valid <= 1'b1;
                        cnt_if.count       <= total;
                    end
                end
                FULL: begin
                    if (cnt_if.count_ready) begin
                        if (close) begin
                            // Accept the held word and reload in the same cycle.
                            cnt_if.count <= total;
                        end else begin
                            state              <= EMPTY;
                            cnt_if.count_valid <= 1'b0;
                        end
                    end else if (close && (drops != DROP_MAX)) begin
                        drops <= drops + DROP_W'(1);
                    end
                end
                default: begin
                    state              <= EMPTY;
                    cnt_if.count_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_token_window_counter.sv
// tb/tb_token_window_counter.sv - directed vector bench for token_window_counter
module tb_token_window_counter;
    localparam int WINDOW = 4;
    localparam int CNT_W  = $clog2(WINDOW + 1);

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       a;
    logic [7:0] drops;

    logic       rst2;
    logic       en2;
    logic       a2;
    logic [1:0] drops2;

    int tests  = 0;
    int failed = 0;

    token_window_counter_if #(.CNT_W(CNT_W)) bus  ();
    token_window_counter_if #(.CNT_W(CNT_W)) bus2 ();

    token_window_counter #(.WINDOW(WINDOW), .DROP_W(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .a      (a),
        .cnt_if (bus.master),
        .drops  (drops)
    );

    token_window_counter #(.WINDOW(WINDOW), .DROP_W(2)) dut2 (
        .clk    (clk),
        .rst    (rst2),
        .en     (en2),
        .a      (a2),
        .cnt_if (bus2.master),
        .drops  (drops2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst;
        logic en;
        logic a;
        logic rdy;
        int   v;
        int   c;
        int   d;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic e, input logic ai, input logic rd,
                       input int v, input int c, input int d);
        vec_t t;
        t.rst = r; t.en = e; t.a = ai; t.rdy = rd; t.v = v; t.c = c; t.d = d;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; a = 1'b1; bus.count_ready = 1'b1;
        rst2 = 1'b0; en2 = 1'b1; a2 = 1'b1; bus2.count_ready = 1'b0;

        // reset with tokens present: everything stays clear
        for (int i = 0; i < 3; i++) add(0, 1, 1, 1, 0, 0, 0);
        // W1, W2: continuous tokens, consumer always ready
        for (int i = 0; i < 3; i++) add(1, 1, 1, 1, 0, 0, 0);
        add(1, 1, 1, 1, 1, 4, 0);
        for (int i = 0; i < 3; i++) add(1, 1, 1, 1, 0, 4, 0);
        add(1, 1, 1, 1, 1, 4, 0);
        // W3: 1010 -> 2
        add(1, 1, 1, 1, 0, 4, 0); add(1, 1, 0, 1, 0, 4, 0);
        add(1, 1, 1, 1, 0, 4, 0); add(1, 1, 0, 1, 1, 2, 0);
        // W4: empty window still pulses valid
        for (int i = 0; i < 3; i++) add(1, 1, 0, 1, 0, 2, 0);
        add(1, 1, 0, 1, 1, 0, 0);
        // W5: accept then stall; W6, W7 closes are dropped
        add(1, 1, 1, 1, 0, 0, 0); add(1, 1, 1, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0); add(1, 1, 1, 0, 1, 4, 0);
        for (int i = 0; i < 3; i++) add(1, 1, 1, 0, 1, 4, 0);
        add(1, 1, 1, 0, 1, 4, 1);
        for (int i = 0; i < 3; i++) add(1, 1, 1, 0, 1, 4, 1);
        add(1, 1, 1, 0, 1, 4, 2);
        // accept with en low: handshake ignores en
        add(1, 0, 1, 1, 0, 4, 2);
        // W8 loads 4 and is held; W9 (0110) closes with ready -> reload 2
        for (int i = 0; i < 3; i++) add(1, 1, 1, 0, 0, 4, 2);
        add(1, 1, 1, 0, 1, 4, 2);
        add(1, 1, 0, 0, 1, 4, 2); add(1, 1, 1, 0, 1, 4, 2);
        add(1, 1, 1, 0, 1, 4, 2); add(1, 1, 0, 1, 1, 2, 2);
        // W10: one enabled cycle, 5 frozen cycles with toggling a, then 1,1,1
        add(1, 1, 0, 1, 0, 2, 2);
        add(1, 0, 1, 1, 0, 2, 2); add(1, 0, 0, 1, 0, 2, 2); add(1, 0, 1, 1, 0, 2, 2);
        add(1, 0, 0, 1, 0, 2, 2); add(1, 0, 1, 1, 0, 2, 2);
        add(1, 1, 1, 1, 0, 2, 2); add(1, 1, 1, 1, 0, 2, 2); add(1, 1, 1, 1, 1, 3, 2);
        // W11: two tokens then reset mid-window; only post-reset tokens count
        add(1, 1, 1, 1, 0, 3, 2); add(1, 1, 1, 1, 0, 3, 2);
        add(0, 1, 1, 1, 0, 0, 0);
        add(1, 1, 0, 1, 0, 0, 0); add(1, 1, 1, 1, 0, 0, 0);
        add(1, 1, 0, 1, 0, 0, 0); add(1, 1, 1, 1, 1, 2, 0);
        // reset discards a held, unconsumed count
        add(0, 1, 1, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; en = vecs[i].en; a = vecs[i].a;
            bus.count_ready = vecs[i].rdy;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d count_valid", i), int'(bus.count_valid), vecs[i].v);
            check($sformatf("vec%0d count", i), int'(bus.count), vecs[i].c);
            check($sformatf("vec%0d drops", i), int'(drops), vecs[i].d);
        end

        // DROP_W=2 instance: six stalled windows, drops saturates at 3
        check("sat reset drops", int'(drops2), 0);
        check("sat reset valid", int'(bus2.count_valid), 0);
        rst2 = 1'b1; en2 = 1'b1; a2 = 1'b1; bus2.count_ready = 1'b0;
        for (int w = 0; w < 6; w++) begin
            for (int k = 0; k < WINDOW; k++) begin
                @(posedge clk);
                #1;
            end
            check($sformatf("sat win%0d drops", w), int'(drops2), (w < 3) ? w : 3);
            check($sformatf("sat win%0d valid", w), int'(bus2.count_valid), 1);
            check($sformatf("sat win%0d count", w), int'(bus2.count), 4);
        end
        bus2.count_ready = 1'b1; en2 = 1'b0;
        @(posedge clk);
        #1;
        check("sat accept valid", int'(bus2.count_valid), 0);
        check("sat accept drops", int'(drops2), 3);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
